// File: rtl/univ_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_pkg
// Description : Shared constants for the universal shift register. This file
//               holds the operation-select encodings and the word-tracking
//               state encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package univ_shift_pkg;

    // Operation select
    localparam int                MODE_W     = 3;
    localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHL   = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHR   = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL   = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR   = 3'b101;
    localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b110;
    localparam logic [MODE_W-1:0] MODE_RSVD  = 3'b111;

    // Word-tracking state: IDLE = no loaded word in flight
    localparam int              ST_W      = 1;
    localparam logic [ST_W-1:0] ST_IDLE   = 1'b0;
    localparam logic [ST_W-1:0] ST_ACTIVE = 1'b1;

endpackage : univ_shift_pkg
`default_nettype wire

// File: rtl/univ_shift_cnt.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_cnt
// Description : Counts the shifts applied to a loaded word and produces a
//               one-cycle done pulse when the WIDTH-th shift completes.
//               Tracks IDLE/ACTIVE (word loaded) state.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-low reset
//               en    - clock enable (en=0 freezes state, clears done)
//               load  - word loaded: go ACTIVE, restart count
//               clear - register cleared: go IDLE, zero count
//               step  - a shift/rotate is applied this cycle
//               cnt   - shifts since last load/clear
//               done  - registered pulse after the WIDTH-th shift
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_cnt
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             clear,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // done defaults low every cycle so a pulse can never stretch, including
    // across en=0 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        if (en) begin
            if (load) begin
                w_state_nxt = ST_ACTIVE;
                w_cnt_nxt   = '0;
            end else if (clear) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else if (step && (r_state == ST_ACTIVE)) begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end
    end

    assign cnt  = r_cnt;
    assign done = r_done;

endmodule : univ_shift_cnt
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Parametrised universal shift register: hold, logical shift
//               left/right, parallel load, clear and (optionally) rotate.
//               Serial in/out on both ends, full parallel out, shift counter
//               with a one-cycle done pulse.
// Config      : UNIV_SHIFT_ROTATE_EN - when defined, modes ROL/ROR rotate and
//               count as shifts; otherwise they decode as HOLD.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset
//               en       - clock enable
//               mode     - operation select (see univ_shift_pkg)
//               din      - parallel load data
//               sin_l    - serial in to bit 0 on SHL
//               sin_r    - serial in to bit WIDTH-1 on SHR
//               pout     - register contents
//               sout_msb - pout[WIDTH-1]
//               sout_lsb - pout[0]
//               cnt      - shifts since last LOAD/CLEAR
//               done     - one-cycle pulse after WIDTH-th shift
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  din,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  pout,
    output logic              sout_msb,
    output logic              sout_lsb,
    output logic [CNT_W-1:0]  cnt,
    output logic              done
);

    logic [WIDTH-1:0] r_pout;
    logic [WIDTH-1:0] w_pout_nxt;
    logic             w_load;
    logic             w_clear;
    logic             w_step;

    always_comb begin
        w_pout_nxt = r_pout;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        w_step     = 1'b0;
        case (mode)
            MODE_SHL: begin
                w_pout_nxt = {r_pout[WIDTH-2:0], sin_l};
                w_step     = 1'b1;
            end
            MODE_SHR: begin
                w_pout_nxt = {sin_r, r_pout[WIDTH-1:1]};
                w_step     = 1'b1;
            end
            MODE_LOAD: begin
                w_pout_nxt = din;
                w_load     = 1'b1;
            end
`ifdef UNIV_SHIFT_ROTATE_EN
            MODE_ROL: begin
                w_pout_nxt = {r_pout[WIDTH-2:0], r_pout[WIDTH-1]};
                w_step     = 1'b1;
            end
            MODE_ROR: begin
                w_pout_nxt = {r_pout[0], r_pout[WIDTH-1:1]};
                w_step     = 1'b1;
            end
`endif
            MODE_CLEAR: begin
                w_pout_nxt = '0;
                w_clear    = 1'b1;
            end
            // HOLD, reserved, and rotate codes when rotate is not built
            default: begin
                w_pout_nxt = r_pout;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pout <= '0;
        end else if (en) begin
            r_pout <= w_pout_nxt;
        end
    end

    univ_shift_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (w_load),
        .clear (w_clear),
        .step  (w_step),
        .cnt   (cnt),
        .done  (done)
    );

    assign pout     = r_pout;
    assign sout_msb = r_pout[WIDTH-1];
    assign sout_lsb = r_pout[0];

endmodule : univ_shift_reg
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Self-checking bench for univ_shift_reg (WIDTH=8): vector
//               table, directed corner sequences and random traffic against
//               a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] din;
    logic         sin_l;
    logic         sin_r;
    logic [W-1:0] pout;
    logic         sout_msb;
    logic         sout_lsb;
    logic [3:0]   cnt;
    logic         done;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .en       (en),
        .mode     (mode),
        .din      (din),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
        .pout     (pout),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .cnt      (cnt),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model
    int m_pout;
    int m_cnt;
    bit m_done;
    bit m_loaded;

    typedef struct {
        logic [2:0]   mode;
        logic [W-1:0] din;
        logic         sl;
        logic         sr;
        logic [W-1:0] exp_pout;
        int           exp_cnt;
        logic         exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pout = 0; m_cnt = 0; m_done = 0; m_loaded = 0;
    endtask

    task automatic model_shift(input int nv);
        m_pout = nv & 'hFF;
        m_done = 0;
        if (m_loaded) begin
            m_cnt++;
            if (m_cnt == W) begin
                m_cnt = 0; m_done = 1; m_loaded = 0;
            end
        end
    endtask

    // Advances the model using the inputs presented for the coming edge.
    task automatic model_step();
        if (!en) begin
            m_done = 0;
        end else begin
            case (mode)
                3'd1: model_shift((m_pout << 1) | int'(sin_l));
                3'd2: model_shift((m_pout >> 1) | (int'(sin_r) << (W - 1)));
                3'd3: begin m_pout = int'(din); m_cnt = 0; m_done = 0; m_loaded = 1; end
`ifdef UNIV_SHIFT_ROTATE_EN
                3'd4: model_shift((m_pout << 1) | (m_pout >> (W - 1)));
                3'd5: model_shift((m_pout >> 1) | ((m_pout & 1) << (W - 1)));
`endif
                3'd6: begin m_pout = 0; m_cnt = 0; m_done = 0; m_loaded = 0; end
                default: m_done = 0;
            endcase
        end
    endtask

    task automatic cycle(input logic [2:0] m, input logic [W-1:0] d,
                         input logic sl, input logic sr, input logic e);
        mode = m; din = d; sin_l = sl; sin_r = sr; en = e;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".pout"}, int'(pout), m_pout);
        cmp({tag, ".msb"},  int'(sout_msb), (m_pout >> (W - 1)) & 1);
        cmp({tag, ".lsb"},  int'(sout_lsb), m_pout & 1);
        cmp({tag, ".cnt"},  int'(cnt), m_cnt);
        cmp({tag, ".done"}, int'(done), int'(m_done));
    endtask

    task automatic add(input logic [2:0] m, input logic [W-1:0] d, input logic sl,
                       input logic sr, input logic [W-1:0] p, input int c, input logic dn);
        vec_t v;
        v.mode = m; v.din = d; v.sl = sl; v.sr = sr;
        v.exp_pout = p; v.exp_cnt = c; v.exp_done = dn;
        vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] p;
        rst_n = 1'b0; en = 1'b0; mode = 3'd0; din = '0; sin_l = 1'b0; sin_r = 1'b0;
        model_reset();

        // Vector table
        add(3'd3, 8'hA5, 0, 0, 8'hA5, 0, 0);
        add(3'd3, 8'h81, 0, 0, 8'h81, 0, 0);
        add(3'd1, 8'h00, 0, 0, 8'h02, 1, 0);
        add(3'd1, 8'h00, 0, 0, 8'h04, 2, 0);
        add(3'd1, 8'h00, 0, 0, 8'h08, 3, 0);
        add(3'd1, 8'h00, 0, 0, 8'h10, 4, 0);
        add(3'd1, 8'h00, 0, 0, 8'h20, 5, 0);
        add(3'd1, 8'h00, 0, 0, 8'h40, 6, 0);
        add(3'd1, 8'h00, 0, 0, 8'h80, 7, 0);
        add(3'd1, 8'h00, 0, 0, 8'h00, 0, 1);
        add(3'd0, 8'h00, 0, 0, 8'h00, 0, 0);
        add(3'd3, 8'h01, 0, 0, 8'h01, 0, 0);
        add(3'd2, 8'h00, 0, 1, 8'h80, 1, 0);
        add(3'd2, 8'h00, 0, 1, 8'hC0, 2, 0);
        add(3'd2, 8'h00, 0, 1, 8'hE0, 3, 0);
        add(3'd7, 8'h00, 0, 0, 8'hE0, 3, 0);
        add(3'd6, 8'h00, 0, 0, 8'h00, 0, 0);
        add(3'd1, 8'h00, 1, 0, 8'h01, 0, 0);

        // Reset state, with reset held across edges
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.pout", int'(pout), 0);
        cmp("reset.cnt",  int'(cnt), 0);
        cmp("reset.done", int'(done), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].mode, vecs[i].din, vecs[i].sl, vecs[i].sr, 1'b1);
            cmp($sformatf("vec%0d.pout", i), int'(pout), int'(vecs[i].exp_pout));
            cmp($sformatf("vec%0d.cnt", i),  int'(cnt), vecs[i].exp_cnt);
            cmp($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].exp_done));
            p = vecs[i].exp_pout;
            cmp($sformatf("vec%0d.msb", i),  int'(sout_msb), int'(p[W-1]));
            cmp($sformatf("vec%0d.lsb", i),  int'(sout_lsb), int'(p[0]));
        end

        // Rotate (or HOLD when rotate is not built)
        cycle(3'd3, 8'h81, 0, 0, 1'b1);
        cycle(3'd4, 8'h00, 0, 0, 1'b1);
`ifdef UNIV_SHIFT_ROTATE_EN
        cmp("rol.pout", int'(pout), 'h03);
        cmp("rol.cnt",  int'(cnt), 1);
`else
        cmp("rol.pout", int'(pout), 'h81);
        cmp("rol.cnt",  int'(cnt), 0);
`endif
        cycle(3'd5, 8'h00, 0, 0, 1'b1);
        cmp("ror.pout", int'(pout), 'h81);
`ifdef UNIV_SHIFT_ROTATE_EN
        cmp("ror.cnt",  int'(cnt), 2);
`else
        cmp("ror.cnt",  int'(cnt), 0);
`endif

        // Enable freeze then reload mid-word
        cycle(3'd3, 8'hFF, 0, 0, 1'b1);
        repeat (4) cycle(3'd1, 8'h00, 0, 0, 1'b1);
        cmp("frz.pre.pout", int'(pout), 'hF0);
        cmp("frz.pre.cnt",  int'(cnt), 4);
        for (int k = 0; k < 3; k++) begin
            cycle(3'd1, 8'h00, 1, 1, 1'b0);
            cmp("frz.pout", int'(pout), 'hF0);
            cmp("frz.cnt",  int'(cnt), 4);
            cmp("frz.done", int'(done), 0);
        end
        cycle(3'd3, 8'h0F, 0, 0, 1'b1);
        cmp("reload.pout", int'(pout), 'h0F);
        cmp("reload.cnt",  int'(cnt), 0);
        cmp("reload.done", int'(done), 0);
        for (int k = 0; k < 4; k++) begin
            cycle(3'd2, 8'h00, 0, 0, 1'b1);
            check_model("reload.sh");
        end

        // en=0 on the cycle after the 8th shift must not extend done
        cycle(3'd3, 8'h3C, 0, 0, 1'b1);
        repeat (8) cycle(3'd1, 8'h00, 1, 0, 1'b1);
        cmp("pulse.done", int'(done), 1);
        cycle(3'd1, 8'h00, 1, 0, 1'b0);
        cmp("pulse.gone", int'(done), 0);
        check_model("pulse");

        // Async reset mid-word
        cycle(3'd3, 8'hFF, 0, 0, 1'b1);
        repeat (5) cycle(3'd1, 8'h00, 0, 0, 1'b1);
        cmp("arst.pre.cnt", int'(cnt), 5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cmp("arst.pout", int'(pout), 0);
        cmp("arst.cnt",  int'(cnt), 0);
        cmp("arst.done", int'(done), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle(3'd1, 8'h00, 1, 0, 1'b1);
            check_model("arst.post");
        end

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [2:0] rm;
            int r;
            r = $urandom_range(0, 15);
            if (r < 9)       rm = 3'($urandom_range(1, 2));
            else if (r < 11) rm = 3'($urandom_range(4, 5));
            else             rm = 3'($urandom_range(0, 7));
            cycle(rm, 8'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) != 0));
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_univ_shift_reg
`default_nettype wire
